phase_sel_ctrl: RTL and testbench
=================================

PHASE_SEL_CTRL -- requirements
Module: phase_sel_ctrl

Interface
REQ-001 Parameter NPH, default 8: number of interpolator phases; power of two, 4..16.
REQ-002 Parameter THRESH, default 4: accumulator magnitude that triggers a phase step; range 1..12.
REQ-003 Parameter HOLD, default 2: vote periods ignored after each phase step; range 0..7.
REQ-004 Parameter LOCK_CNT, default 16: consecutive step-free vote periods required to assert locked; range 2..255.
REQ-005 clk  input  1  sampling clock; the clock that also drives the upstream vote counter.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 enable  input  1  loop enable; synchronous to clk.
REQ-008 clk_cont  input  1  vote-period strobe, level signal from upstream vote logic; generated from clk.
REQ-009 ea  input  2  early-vote count for the last period, 0..3.
REQ-010 la  input  2  late-vote count for the last period, 0..3.
REQ-011 phase_idx  output  log2(NPH)  current phase index, registered.
REQ-012 phase_sel  output  NPH  one-hot decode of phase_idx, registered.
REQ-013 up  output  1  one-clk pulse on an increment step.
REQ-014 dn  output  1  one-clk pulse on a decrement step.
REQ-015 locked  output  1  lock indicator, registered.

Function
REQ-016 Rising edges of clk_cont SHALL be detected with one flop (vs_stb = clk_cont & ~clk_cont_q); ea and la SHALL be sampled one clk after vs_stb (vote cycle).
REQ-017 Each vote cycle SHALL form signed d = ea - la, range -3..+3.
REQ-018 The FSM SHALL have exactly three states: IDLE, TRACK, HOLD.
REQ-019 IDLE: acc held at 0, no steps; exit to TRACK on the first clk with enable=1.
REQ-020 TRACK: on each vote cycle, acc_next = acc + d; acc is a 5-bit signed register, and no overflow is possible within the parameter ranges.
REQ-021 If acc_next >= +THRESH: phase_idx increments modulo NPH, up pulses for 1 clk, acc is cleared to 0, and the FSM goes to HOLD (to TRACK if HOLD=0).
REQ-022 If acc_next <= -THRESH: phase_idx decrements modulo NPH, dn pulses for 1 clk, acc is cleared, and the FSM transitions as in REQ-021.
REQ-023 Wrap-around: idx NPH-1 with up gives 0; idx 0 with dn gives NPH-1.
REQ-024 HOLD: the next HOLD vote cycles are discarded (acc unchanged, no steps); return to TRACK after the HOLDth discarded vote.
REQ-025 A vote cycle with ea == la SHALL leave acc unchanged and count as step-free.
REQ-026 enable=0 in any state SHALL move to IDLE on the next clk, clear acc, hold phase_idx, clear the lock counter, and deassert locked.
REQ-027 phase_sel SHALL update in the same clk as phase_idx; it SHALL always be one-hot, never zero and never multi-hot.
REQ-028 up and dn SHALL never assert in the same clk, and there SHALL be at most one step per vote period.
REQ-029 A vs_stb that arrives while a vote cycle is pending SHALL not be lost; the strobe spacing of at least 6 clk makes this impossible by construction, and the bench SHALL check it.

Reset
REQ-030 While rst=1, outputs SHALL take these values asynchronously: phase_idx=0, phase_sel=1 (bit0), up=0, dn=0, locked=0.
REQ-031 While rst=1, internal state SHALL take these values: acc=0, FSM=IDLE, hold and lock counters=0, clk_cont_q=0.
REQ-032 Reset mid-step or mid-HOLD SHALL abort the operation; there are no residual pulses after release.

Configuration
REQ-033 Macro PHSEL_LOCK_DET_EN defined: the lock counter increments on each step-free TRACK vote cycle and saturates at LOCK_CNT; locked=1 when the count equals LOCK_CNT; any step clears the counter and locked in the same clk as up/dn.
REQ-034 Macro PHSEL_LOCK_DET_EN undefined: there is no lock counter and locked is tied to 0.

Verification
REQ-035 Scenario: reset release, enable=1, ea=2, la=0 every period (THRESH=4) -> acc 2, then 4 -> up on the 2nd vote cycle, phase_idx 0->1, phase_sel 0x01->0x02.
REQ-036 Scenario: phase_idx=0, ea=0, la=3 for two periods -> dn on the 2nd vote cycle, phase_idx=7, phase_sel=0x80 (wrap); the 2 following votes are ignored (HOLD=2).
REQ-037 Scenario: ea=la=1 for 16 periods with the macro defined -> no up/dn, locked=1 after the 16th vote cycle; one ea=3 then ea=1 pair -> up, and locked drops in the same clk.
REQ-038 Scenario: enable deasserted with acc=3 -> next clk acc=0, FSM=IDLE, phase_idx held; re-enable followed by ea=1 votes -> 4 votes are needed before up.
REQ-039 Scenario: rst asserted during HOLD with phase_idx=5 -> phase_idx=0 and phase_sel=0x01 immediately; no up/dn within 20 clk after release with enable=0.
REQ-040 Scenario: random ea/la for 10k periods -> phase_sel always one-hot, up & dn never both high, at most 1 step per clk_cont period.

Source files
------------

// File: rtl/phase_sel_ctrl.sv
// phase_sel_ctrl -- bang-bang phase selector for a phase interpolator.
//
// Accumulates early/late vote counts delivered once per vote period and
// steps the selected interpolator phase up or down when the accumulated
// imbalance reaches THRESH. After each step a number of vote periods
// (HOLD) is ignored so the loop can settle on the new phase.
//
// Optional feature: define PHSEL_LOCK_DET_EN to build the lock detector.
// Without it, locked is tied low.
//
// Parameters
//   NPH       number of interpolator phases (power of two, 4..16)
//   THRESH    accumulator magnitude that triggers a step (1..12)
//   HOLD      vote periods ignored after each step (0..7)
//   LOCK_CNT  consecutive step-free votes needed for locked (2..255)
//
// Ports
//   clk        sampling clock
//   rst        asynchronous active-high reset
//   enable     loop enable
//   clk_cont   vote-period strobe (level), rising edge marks a new vote
//   ea, la     early / late vote counts for the last period (0..3)
//   phase_idx  current phase index (registered)
//   phase_sel  one-hot decode of phase_idx (registered)
//   up, dn     one-clk step pulses
//   locked     lock indicator (registered)

module phase_sel_ctrl #(
    parameter int unsigned NPH      = 8,
    parameter int unsigned THRESH   = 4,
    parameter int unsigned HOLD     = 2,
    parameter int unsigned LOCK_CNT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clk_cont,
    input  logic [1:0]             ea,
    input  logic [1:0]             la,
    output logic [$clog2(NPH)-1:0] phase_idx,
    output logic [NPH-1:0]         phase_sel,
    output logic                   up,
    output logic                   dn,
    output logic                   locked
);

    localparam int unsigned        IW        = $clog2(NPH);
    localparam logic signed [4:0]  TH_POS    = 5'(THRESH);
    localparam logic signed [4:0]  TH_NEG    = -TH_POS;
    localparam logic [2:0]         HOLD_LAST = (HOLD == 0) ? 3'd0 : 3'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD
    } state_t;

    state_t             state_q, state_n;
    logic               clk_cont_q;
    logic               vs_stb;
    logic               vote_pend;
    logic signed [4:0]  acc_q, acc_n;
    logic signed [4:0]  d;
    logic signed [4:0]  acc_sum;
    logic [2:0]         hold_q, hold_n;
    logic [IW-1:0]      idx_n;
    logic [NPH-1:0]     sel_n;
    logic               up_n, dn_n;

    // Rising edge of the vote strobe; the vote itself is consumed one clk
    // later so ea/la have settled from the upstream counter.
    assign vs_stb  = clk_cont & ~clk_cont_q;
    assign d       = $signed({3'b000, ea}) - $signed({3'b000, la});
    assign acc_sum = acc_q + d;

    always_comb begin
        state_n = state_q;
        acc_n   = acc_q;
        hold_n  = hold_q;
        idx_n   = phase_idx;
        up_n    = 1'b0;
        dn_n    = 1'b0;

        if (!enable) begin
            state_n = ST_IDLE;
            acc_n   = '0;
            hold_n  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n = ST_TRACK;
                    acc_n   = '0;
                end
                ST_TRACK: begin
                    if (vote_pend) begin
                        if (acc_sum >= TH_POS) begin
                            up_n  = 1'b1;
                            idx_n = phase_idx + IW'(1);
                        end else if (acc_sum <= TH_NEG) begin
                            dn_n  = 1'b1;
                            idx_n = phase_idx - IW'(1);
                        end else begin
                            acc_n = acc_sum;
                        end
                        if (up_n || dn_n) begin
                            acc_n   = '0;
                            hold_n  = '0;
                            state_n = (HOLD == 0) ? ST_TRACK : ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (vote_pend) begin
                        if (hold_q == HOLD_LAST) begin
                            state_n = ST_TRACK;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_q + 3'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        sel_n        = '0;
        sel_n[idx_n] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clk_cont_q <= 1'b0;
            vote_pend  <= 1'b0;
            acc_q      <= '0;
            hold_q     <= '0;
            phase_idx  <= '0;
            phase_sel  <= {{(NPH-1){1'b0}}, 1'b1};
            up         <= 1'b0;
            dn         <= 1'b0;
        end else begin
            state_q    <= state_n;
            clk_cont_q <= clk_cont;
            vote_pend  <= vs_stb;
            acc_q      <= acc_n;
            hold_q     <= hold_n;
            phase_idx  <= idx_n;
            phase_sel  <= sel_n;
            up         <= up_n;
            dn         <= dn_n;
        end
    end

`ifdef PHSEL_LOCK_DET_EN
    localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);

    logic [7:0] lock_q, lock_n;
    logic       clean_vote;

    // Only votes consumed in TRACK that do not cause a step count toward lock.
    assign clean_vote = enable && (state_q == ST_TRACK) && vote_pend && !up_n && !dn_n;

    always_comb begin
        lock_n = lock_q;
        if (!enable || up_n || dn_n) begin
            lock_n = '0;
        end else if (clean_vote && (lock_q != LOCK_MAX)) begin
            lock_n = lock_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            locked <= 1'b0;
        end else begin
            lock_q <= lock_n;
            locked <= (lock_n == LOCK_MAX);
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_sel_ctrl.sv
`timescale 1ns/1ps
// Testbench for phase_sel_ctrl: table-driven directed vectors, hand-written
// corner sequences and randomized votes against a vote-level reference model.
module tb_phase_sel_ctrl;

    localparam int NPH      = 8;
    localparam int THRESH   = 4;
    localparam int HOLD     = 2;
    localparam int LOCK_CNT = 16;
    localparam int IW       = $clog2(NPH);
`ifdef PHSEL_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           clk_cont;
    logic [1:0]     ea;
    logic [1:0]     la;
    logic [IW-1:0]  phase_idx;
    logic [NPH-1:0] phase_sel;
    logic           up;
    logic           dn;
    logic           locked;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, kept per vote period.
    int m_acc, m_hold_left, m_idx, m_lock;
    bit m_en;

    phase_sel_ctrl #(
        .NPH      (NPH),
        .THRESH   (THRESH),
        .HOLD     (HOLD),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clk_cont  (clk_cont),
        .ea        (ea),
        .la        (la),
        .phase_idx (phase_idx),
        .phase_sel (phase_sel),
        .up        (up),
        .dn        (dn),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic m_reset();
        m_acc = 0; m_hold_left = 0; m_idx = 0; m_lock = 0; m_en = 1'b0;
    endtask

    task automatic model_vote(input int e, input int l, output bit x_up, output bit x_dn);
        x_up = 1'b0;
        x_dn = 1'b0;
        if (!m_en) return;
        if (m_hold_left > 0) begin
            m_hold_left--;
            return;
        end
        m_acc = m_acc + e - l;
        if (m_acc >= THRESH) begin
            x_up  = 1'b1;
            m_idx = (m_idx + 1) % NPH;
        end else if (m_acc <= -THRESH) begin
            x_dn  = 1'b1;
            m_idx = (m_idx + NPH - 1) % NPH;
        end else begin
            if (m_lock < LOCK_CNT) m_lock++;
            return;
        end
        m_acc = 0;
        m_hold_left = HOLD;
        m_lock = 0;
    endtask

    function automatic int exp_locked();
        return int'(LOCK_EN && (m_lock == LOCK_CNT));
    endfunction

    // One 6-clk vote period starting at a negedge; clk_cont high for hi clks.
    // The vote's effect is visible after the second posedge (c == 1).
    task automatic vote(input logic [1:0] e, input logic [1:0] l, input int hi,
                        input string tag, output logic o_up, output logic o_dn,
                        output logic o_lk);
        int n_up, n_dn, bad;
        bit x_up, x_dn;
        n_up = 0; n_dn = 0; bad = 0;
        o_up = 1'b0; o_dn = 1'b0; o_lk = 1'b0;
        ea = e; la = l; clk_cont = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (up) n_up++;
            if (dn) n_dn++;
            if (up && dn) bad++;
            if ($countones(phase_sel) != 1 || !phase_sel[phase_idx]) bad++;
            if (c == 1) begin
                o_up = up; o_dn = dn; o_lk = locked;
            end
            if (c == hi - 1) clk_cont = 1'b0;
        end
        model_vote(int'(e), int'(l), x_up, x_dn);
        chk({tag, " up"}, int'(o_up), int'(x_up));
        chk({tag, " dn"}, int'(o_dn), int'(x_dn));
        chk({tag, " steps"}, n_up + n_dn, int'(x_up) + int'(x_dn));
        chk({tag, " idx"}, int'(phase_idx), m_idx);
        chk({tag, " locked"}, int'(o_lk), exp_locked());
        chk({tag, " invariants"}, bad, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; clk_cont = 1'b0; ea = 2'd0; la = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst idx", int'(phase_idx), 0);
        chk("rst sel", int'(phase_sel), 1);
        chk("rst up", int'(up), 0);
        chk("rst dn", int'(dn), 0);
        chk("rst locked", int'(locked), 0);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
    endtask

    task automatic en_on();
        enable = 1'b1;
        m_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic en_off();
        enable = 1'b0;
        m_en = 1'b0; m_acc = 0; m_hold_left = 0; m_lock = 0;
        @(negedge clk);
        chk("dis idx held", int'(phase_idx), m_idx);
        chk("dis up", int'(up), 0);
        chk("dis dn", int'(dn), 0);
        chk("dis locked", int'(locked), 0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] ea;
        logic [1:0] la;
        bit         up;
        bit         dn;
        int         idx;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic u, d, lk;
        int   cnt;

        tbl = '{
            '{2'd2, 2'd0, 1'b0, 1'b0, 0},
            '{2'd2, 2'd0, 1'b1, 1'b0, 1},
            '{2'd2, 2'd0, 1'b0, 1'b0, 1},
            '{2'd2, 2'd0, 1'b0, 1'b0, 1},
            '{2'd0, 2'd3, 1'b0, 1'b0, 1},
            '{2'd0, 2'd3, 1'b0, 1'b1, 0},
            '{2'd3, 2'd0, 1'b0, 1'b0, 0},
            '{2'd3, 2'd0, 1'b0, 1'b0, 0},
            '{2'd0, 2'd3, 1'b0, 1'b0, 0},
            '{2'd0, 2'd3, 1'b0, 1'b1, 7},
            '{2'd3, 2'd3, 1'b0, 1'b0, 7},
            '{2'd1, 2'd0, 1'b0, 1'b0, 7},
            '{2'd1, 2'd1, 1'b0, 1'b0, 7},
            '{2'd3, 2'd0, 1'b0, 1'b0, 7},
            '{2'd1, 2'd0, 1'b1, 1'b0, 0}
        };

        // Directed table: step up, hold, step down, wrap down, wrap up.
        do_reset();
        en_on();
        foreach (tbl[i]) begin
            vote(tbl[i].ea, tbl[i].la, 3, "tbl", u, d, lk);
            chk("tbl vec up", int'(u), int'(tbl[i].up));
            chk("tbl vec dn", int'(d), int'(tbl[i].dn));
            chk("tbl vec idx", int'(phase_idx), tbl[i].idx);
            chk("tbl vec sel", int'(phase_sel), 1 << tbl[i].idx);
        end

        // Lock acquisition after LOCK_CNT balanced votes, loss on a step.
        do_reset();
        en_on();
        for (int k = 0; k < LOCK_CNT; k++) begin
            vote(2'd1, 2'd1, 2, "lock", u, d, lk);
            if (k == LOCK_CNT - 2) chk("lock early", int'(locked), 0);
        end
        chk("lock after 16", int'(locked), int'(LOCK_EN));
        vote(2'd3, 2'd0, 2, "lock", u, d, lk);
        vote(2'd1, 2'd0, 2, "lock", u, d, lk);
        chk("lock step up", int'(u), 1);
        chk("lock drop with up", int'(lk), 0);
        chk("lock step idx", int'(phase_idx), 1);

        // Disable with acc=3 clears acc and keeps the phase.
        do_reset();
        en_on();
        vote(2'd3, 2'd0, 3, "dis", u, d, lk);
        vote(2'd1, 2'd0, 3, "dis", u, d, lk);
        vote(2'd0, 2'd0, 3, "dis", u, d, lk);
        vote(2'd0, 2'd0, 3, "dis", u, d, lk);
        vote(2'd3, 2'd0, 3, "dis", u, d, lk);
        en_off();
        en_on();
        for (int k = 0; k < 4; k++) begin
            vote(2'd1, 2'd0, 4, "reen", u, d, lk);
            chk("reen up on 4th", int'(u), int'(k == 3));
        end
        chk("reen idx", int'(phase_idx), 2);

        // Reset while an up pulse is high and the FSM sits in HOLD at idx 5.
        do_reset();
        en_on();
        for (int s = 0; s < 4; s++) begin
            vote(2'd3, 2'd0, 3, "pre", u, d, lk);
            vote(2'd1, 2'd0, 3, "pre", u, d, lk);
            vote(2'd0, 2'd0, 3, "pre", u, d, lk);
            vote(2'd0, 2'd0, 3, "pre", u, d, lk);
        end
        vote(2'd3, 2'd0, 3, "pre", u, d, lk);
        ea = 2'd1; la = 2'd0; clk_cont = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("midrst up before", int'(up), 1);
        chk("midrst idx before", int'(phase_idx), 5);
        rst = 1'b1;
        #1;
        chk("midrst idx", int'(phase_idx), 0);
        chk("midrst sel", int'(phase_sel), 1);
        chk("midrst up", int'(up), 0);
        chk("midrst dn", int'(dn), 0);
        enable = 1'b0; clk_cont = 1'b0; ea = 2'd3;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            clk_cont = ((c % 6) < 3);
            @(posedge clk);
            @(negedge clk);
            if (up || dn) cnt++;
        end
        chk("post-rst pulses", cnt, 0);
        chk("post-rst idx", int'(phase_idx), 0);
        clk_cont = 1'b0;

        // Randomized votes with occasional disables.
        do_reset();
        en_on();
        for (int p = 0; p < 10000; p++) begin
            if ($urandom_range(0, 99) == 0) begin
                en_off();
                en_on();
            end
            vote(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(2, 4)), "rnd", u, d, lk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
